// File: rtl/quadrature_decoder_if.sv
// quadrature_decoder_if: encoder pins, control pulses and decoded outputs of one motor channel
interface quadrature_decoder_if #(
    parameter int POS_WIDTH = 32,
    parameter int VEL_WIDTH = 16
);
    logic                 quad_A;
    logic                 quad_B;
    logic                 quad_I;
    logic                 enable;
    logic                 clear_pos;
    logic                 preload;
    logic [POS_WIDTH-1:0] preload_value;
    logic                 clear_err;
    logic                 index_arm;
    logic [POS_WIDTH-1:0] position;
    logic                 count_pulse;
    logic                 direction;
    logic                 error;
    logic                 index_seen;
    logic [POS_WIDTH-1:0] index_position;
    logic [VEL_WIDTH-1:0] velocity;
    logic                 velocity_valid;

    modport master (
        output quad_A, quad_B, quad_I, enable, clear_pos, preload, preload_value, clear_err, index_arm,
        input  position, count_pulse, direction, error, index_seen, index_position, velocity, velocity_valid
    );

    modport slave (
        input  quad_A, quad_B, quad_I, enable, clear_pos, preload, preload_value, clear_err, index_arm,
        output position, count_pulse, direction, error, index_seen, index_position, velocity, velocity_valid
    );
endinterface

// File: rtl/quadrature_decoder.sv
// quadrature_decoder: synced/filtered x4 quadrature decode, windowed velocity, index capture (QUAD_INDEX_RESET_EN zeroes position on capture)
module quadrature_decoder #(
    parameter int POS_WIDTH    = 32,
    parameter int FILTER_DEPTH = 3,
    parameter int VEL_PERIOD   = 50000,
    parameter int VEL_WIDTH    = 16
) (
    input logic clk,
    input logic reset,
    quadrature_decoder_if.slave bus
);
    localparam int FW     = $clog2(FILTER_DEPTH + 1);
    localparam int WW     = $clog2(VEL_PERIOD + 1);
    localparam int AW     = $clog2(VEL_PERIOD + 1) + 2;
    localparam int SETTLE = FILTER_DEPTH + 3;
    localparam int SW     = $clog2(SETTLE + 1);
    localparam logic signed [63:0] VMAX = (64'sd1 <<< (VEL_WIDTH - 1)) - 64'sd1;
    localparam logic signed [63:0] VMIN = -VMAX - 64'sd1;

    typedef enum logic [1:0] {DISARMED, ARMED, CAPTURED} idx_state_t;

    logic [2:0]           sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d;
    logic [2:0][FW-1:0]   fcnt_q, fcnt_d;
    logic [1:0]           prev_ab_q, prev_ab_d;
    logic                 prev_i_q, prev_i_d;
    logic [SW-1:0]        settle_q, settle_d;
    logic [POS_WIDTH-1:0] position_q, position_d, index_position_q, index_position_d;
    logic                 count_pulse_q, count_pulse_d, direction_q, direction_d;
    logic                 error_q, error_d, index_seen_q, index_seen_d;
    logic [VEL_WIDTH-1:0] velocity_q, velocity_d;
    logic                 velocity_valid_q, velocity_valid_d;
    logic [WW-1:0]        win_q, win_d;
    logic signed [AW-1:0] acc_q, acc_d, delta;
    logic signed [63:0]   acc_x;
    idx_state_t           state_q, state_d;
    logic [1:0]           cur_idx, prev_idx, diff;
    logic                 settled, step_fwd, step_rev, illegal, cnt_en, i_rise, capture, win_end;

    // Per-pin synchroniser plus run-length filter: a level is accepted once FILTER_DEPTH samples agree
    always_comb begin
        sync1_d = {bus.quad_I, bus.quad_B, bus.quad_A};
        sync2_d = sync1_q;
        for (int p = 0; p < 3; p++) begin
            fcnt_d[p] = '0;
            filt_d[p] = filt_q[p];
            if (sync2_q[p] != filt_q[p]) begin
                if (fcnt_q[p] == FW'(FILTER_DEPTH - 1))
                    filt_d[p] = sync2_q[p];
                else
                    fcnt_d[p] = fcnt_q[p] + 1'b1;
            end
        end
    end

    // Quadrature decode, position, error, velocity window and index capture
    always_comb begin
        settled          = settle_q == SW'(SETTLE);
        settle_d         = settled ? settle_q : settle_q + 1'b1;
        cur_idx          = {filt_q[1], filt_q[1] ^ filt_q[0]};
        prev_idx         = {prev_ab_q[1], prev_ab_q[1] ^ prev_ab_q[0]};
        diff             = cur_idx - prev_idx;
        step_fwd         = settled && diff == 2'd1;
        step_rev         = settled && diff == 2'd3;
        illegal          = settled && diff == 2'd2;
        cnt_en           = bus.enable && (step_fwd || step_rev);
        prev_ab_d        = filt_q[1:0];
        prev_i_d         = filt_q[2];
        i_rise           = settled && filt_q[2] && !prev_i_q;
        capture          = state_q == ARMED && i_rise && !bus.index_arm;
        state_d          = bus.index_arm ? ARMED : capture ? CAPTURED : state_q;
        index_seen_d     = bus.index_arm ? 1'b0 : capture ? 1'b1 : index_seen_q;
        index_position_d = capture ? position_q : index_position_q;
        position_d       = bus.clear_pos ? '0 :
                           bus.preload   ? bus.preload_value :
                           cnt_en        ? position_q + (step_rev ? {POS_WIDTH{1'b1}} : POS_WIDTH'(1)) :
                           position_q;
`ifdef QUAD_INDEX_RESET_EN
        if (capture)
            position_d = '0;
`endif
        count_pulse_d    = cnt_en;
        direction_d      = cnt_en ? step_fwd : direction_q;
        error_d          = illegal | (error_q & ~bus.clear_err);
        delta            = !cnt_en ? '0 : step_fwd ? AW'(1) : {AW{1'b1}};
        win_end          = bus.enable && win_q == WW'(VEL_PERIOD - 1);
        win_d            = (!bus.enable || win_end) ? '0 : win_q + 1'b1;
        acc_d            = !bus.enable ? '0 : win_end ? delta : acc_q + delta;
        acc_x            = {{(64 - AW){acc_q[AW-1]}}, acc_q};
        velocity_valid_d = win_end;
        velocity_d       = !win_end      ? velocity_q :
                           acc_x > VMAX ? VMAX[VEL_WIDTH-1:0] :
                           acc_x < VMIN ? VMIN[VEL_WIDTH-1:0] :
                           acc_x[VEL_WIDTH-1:0];
    end

    // State registers, all cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q          <= '0;
            sync2_q          <= '0;
            filt_q           <= '0;
            fcnt_q           <= '0;
            prev_ab_q        <= '0;
            prev_i_q         <= 1'b0;
            settle_q         <= '0;
            position_q       <= '0;
            index_position_q <= '0;
            count_pulse_q    <= 1'b0;
            direction_q      <= 1'b0;
            error_q          <= 1'b0;
            index_seen_q     <= 1'b0;
            velocity_q       <= '0;
            velocity_valid_q <= 1'b0;
            win_q            <= '0;
            acc_q            <= '0;
            state_q          <= DISARMED;
        end else begin
            sync1_q          <= sync1_d;
            sync2_q          <= sync2_d;
            filt_q           <= filt_d;
            fcnt_q           <= fcnt_d;
            prev_ab_q        <= prev_ab_d;
            prev_i_q         <= prev_i_d;
            settle_q         <= settle_d;
            position_q       <= position_d;
            index_position_q <= index_position_d;
            count_pulse_q    <= count_pulse_d;
            direction_q      <= direction_d;
            error_q          <= error_d;
            index_seen_q     <= index_seen_d;
            velocity_q       <= velocity_d;
            velocity_valid_q <= velocity_valid_d;
            win_q            <= win_d;
            acc_q            <= acc_d;
            state_q          <= state_d;
        end
    end

    assign bus.position       = position_q;
    assign bus.count_pulse    = count_pulse_q;
    assign bus.direction      = direction_q;
    assign bus.error          = error_q;
    assign bus.index_seen     = index_seen_q;
    assign bus.index_position = index_position_q;
    assign bus.velocity       = velocity_q;
    assign bus.velocity_valid = velocity_valid_q;
endmodule

// File: tb/tb_quadrature_decoder.sv
// tb_quadrature_decoder: directed checks of decode, filtering, error, preload/clear, velocity and index capture
module tb_quadrature_decoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    int   npulse = 0;
    logic [1:0] fwd_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] rev_seq [4] = '{2'b10, 2'b00, 2'b01, 2'b11};

    always #5 clk = ~clk;

    quadrature_decoder_if #(.POS_WIDTH(32), .VEL_WIDTH(16)) q ();
    quadrature_decoder_if #(.POS_WIDTH(32), .VEL_WIDTH(4))  q4 ();

    quadrature_decoder #(.POS_WIDTH(32), .FILTER_DEPTH(3), .VEL_PERIOD(100), .VEL_WIDTH(16))
        dut (.clk(clk), .reset(reset), .bus(q));
    quadrature_decoder #(.POS_WIDTH(32), .FILTER_DEPTH(3), .VEL_PERIOD(100), .VEL_WIDTH(4))
        dut4 (.clk(clk), .reset(reset), .bus(q4));

    assign q4.quad_A        = q.quad_A;
    assign q4.quad_B        = q.quad_B;
    assign q4.quad_I        = q.quad_I;
    assign q4.enable        = q.enable;
    assign q4.clear_pos     = q.clear_pos;
    assign q4.preload       = q.preload;
    assign q4.preload_value = q.preload_value;
    assign q4.clear_err     = q.clear_err;
    assign q4.index_arm     = q.index_arm;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            npulse += int'(q.count_pulse);
        end
    endtask

    initial begin
        int t;
        q.quad_A = 0; q.quad_B = 0; q.quad_I = 0; q.enable = 1; q.clear_pos = 0;
        q.preload = 0; q.preload_value = '0; q.clear_err = 0; q.index_arm = 0;
        repeat (3) tick();
        chk("rst_position", q.position, 0);
        chk("rst_count_pulse", q.count_pulse, 0);
        chk("rst_direction", q.direction, 0);
        chk("rst_error", q.error, 0);
        chk("rst_index_seen", q.index_seen, 0);
        chk("rst_index_position", q.index_position, 0);
        chk("rst_velocity", q.velocity, 0);
        chk("rst_velocity_valid", q.velocity_valid, 0);
        reset = 0;
        run(10);

        for (int i = 0; i < 8; i++) begin
            q.quad_A = fwd_seq[i % 4][1];
            q.quad_B = fwd_seq[i % 4][0];
            for (int k = 1; k <= 10; k++) begin
                tick();
                chk("fwd_count_pulse", q.count_pulse, (k == 6) ? 1 : 0);
                if (k == 6) chk("fwd_position", q.position, i + 1);
            end
        end
        chk("fwd_final_position", q.position, 8);
        chk("fwd_direction", q.direction, 1);

        npulse = 0;
        q.quad_A = 1; tick(); q.quad_A = 0;
        run(12);
        chk("glitch1_position", q.position, 8);
        chk("glitch1_error", q.error, 0);
        q.quad_A = 1; tick(); tick(); q.quad_A = 0;
        run(12);
        chk("glitch2_position", q.position, 8);
        chk("glitch2_error", q.error, 0);
        chk("glitch_pulses", npulse, 0);

        q.quad_A = 1; q.quad_B = 1;
        run(10);
        chk("illegal_error", q.error, 1);
        chk("illegal_position", q.position, 8);
        chk("illegal_pulses", npulse, 0);
        q.clear_err = 1; tick(); q.clear_err = 0;
        chk("clear_err", q.error, 0);
        q.quad_A = 0; q.quad_B = 0;
        repeat (5) tick();
        q.clear_err = 1; tick(); q.clear_err = 0;
        chk("set_beats_clear", q.error, 1);
        run(4);
        q.clear_err = 1; tick(); q.clear_err = 0;
        chk("clear_err_again", q.error, 0);
        chk("illegal2_position", q.position, 8);

        q.preload_value = 32'h7FFF_FFFF; q.preload = 1; tick(); q.preload = 0;
        chk("preload", q.position, 32'h7FFF_FFFF);
        q.quad_A = 1;
        run(8);
        chk("wrap_position", q.position, 32'h8000_0000);
        q.quad_B = 1;
        repeat (5) tick();
        q.clear_pos = 1; tick(); q.clear_pos = 0;
        chk("clear_beats_count", q.position, 0);

        q.enable = 0; tick(); q.enable = 1;
        for (int i = 0; i < 40; i++) begin
            q.quad_A = rev_seq[i % 4][1];
            q.quad_B = rev_seq[i % 4][0];
            tick(); tick();
        end
        t = 0;
        while (!q.velocity_valid && t < 150) begin
            tick();
            t++;
        end
        chk("vel_valid_seen", q.velocity_valid, 1);
        chk("velocity", q.velocity, 16'hFFD8);
        chk("velocity_sat4", q4.velocity, 4'h8);
        chk("velocity_sat4_valid", q4.velocity_valid, 1);
        tick();
        chk("vel_valid_one_cycle", q.velocity_valid, 0);
        chk("rev_position", q.position, 32'hFFFF_FFD8);
        chk("rev_direction", q.direction, 0);

        q.preload_value = 123; q.preload = 1; tick(); q.preload = 0;
        q.index_arm = 1; tick(); q.index_arm = 0;
        chk("armed_not_seen", q.index_seen, 0);
        q.quad_I = 1;
        run(10);
        chk("index_seen", q.index_seen, 1);
        chk("index_position", q.index_position, 123);
`ifdef QUAD_INDEX_RESET_EN
        chk("index_pos_after", q.position, 0);
`else
        chk("index_pos_after", q.position, 123);
`endif
        q.quad_I = 0;
        run(8);
        q.preload_value = 55; q.preload = 1; tick(); q.preload = 0;
        q.quad_I = 1;
        run(10);
        chk("index2_ignored_pos", q.index_position, 123);
        chk("index2_seen", q.index_seen, 1);
        chk("index2_position", q.position, 55);
        q.quad_I = 0;
        run(8);
        q.quad_I = 1;
        repeat (5) tick();
        q.index_arm = 1; tick(); q.index_arm = 0;
        chk("arm_wins_seen", q.index_seen, 0);
        run(10);
        chk("arm_wins_no_capture", q.index_seen, 0);
        chk("arm_wins_index_pos", q.index_position, 123);
        q.quad_I = 0;

        reset = 1; tick();
        chk("midrst_position", q.position, 0);
        chk("midrst_velocity", q.velocity, 0);
        chk("midrst_index_position", q.index_position, 0);
        chk("midrst_direction", q.direction, 0);
        reset = 0;
        npulse = 0;
        run(12);
        chk("settle_error", q.error, 0);
        chk("settle_position", q.position, 0);
        chk("settle_pulses", npulse, 0);

        q.enable = 0;
        q.quad_A = 0;
        run(10);
        chk("disabled_position", q.position, 0);
        chk("disabled_pulses", npulse, 0);
        q.enable = 1;
        run(5);
        chk("reenable_position", q.position, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
